// File: rtl/brick_pkg.sv
// Shared types and geometry constants for the brick game-state stage.
// Also holds the small arithmetic helpers used by the brick scanner.
package brick_pkg;

   typedef enum logic [1:0] {MENU, PLAY, OVER, WIN} game_state_t;
   typedef enum logic [1:0] {IDLE, SCAN, HIT} scan_state_t;

   localparam int         BRICK_COLS     = 8;
   localparam int         BRICK_COL_W    = $clog2(BRICK_COLS);
   localparam int         BRICK_PITCH_X  = 80;
   localparam int         BRICK_OFFSET_X = 40;
   localparam int         BRICK_PITCH_Y  = 20;
   localparam int         BRICK_OFFSET_Y = 10;
   localparam logic [7:0] KEY_ENTER      = 8'h28;

   function automatic logic [15:0] to_bcd(input int v);
      int          r;
      logic [15:0] b;
      r = v;
      b = '0;
      for (int i = 0; i < 4; i++) begin
         b[i*4 +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return b;
   endfunction

   function automatic logic [10:0] abs_diff(input logic [10:0] a,
                                            input logic [10:0] b);
      return (a >= b) ? a - b : b - a;
   endfunction

endpackage

// File: rtl/bcd_add4.sv
// Four-digit BCD adder; a carry out of the top digit clamps to 9999.
module bcd_add4 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [15:0] sum_o
);

   logic [15:0] raw;
   logic        carry;
   logic [4:0]  dig;

   always_comb begin
      raw   = '0;
      carry = 1'b0;
      dig   = '0;
      for (int i = 0; i < 4; i++) begin
         dig = {1'b0, a_i[i*4 +: 4]} + {1'b0, b_i[i*4 +: 4]} + {4'd0, carry};
         if (dig > 5'd9) begin
            dig   = dig - 5'd10;
            carry = 1'b1;
         end else begin
            carry = 1'b0;
         end
         raw[i*4 +: 4] = dig[3:0];
      end
   end

   assign sum_o = carry ? 16'h9999 : raw;

endmodule

// File: rtl/brick_state_ctrl.sv
// Brick field, lives, score and game FSM; scans one brick per cycle per frame.
// Define EXTRA_LIFE_EN to grant a life at each 200-point score boundary.
module brick_state_ctrl
   import brick_pkg::*;
#(
   parameter int NUM_BLOCKS  = 32,
   parameter int HIT_POINTS  = 10,
   parameter int START_LIVES = 3
) (
   input  logic        clk,
   input  logic        Reset_n,
   input  logic        frame_clk,
   input  logic [9:0]  BallX,
   input  logic [9:0]  BallY,
   input  logic [9:0]  Ball_size,
   input  logic [9:0]  Block_SizeX,
   input  logic [9:0]  Block_SizeY,
   input  logic        ball_lost,
   input  logic [7:0]  keycode,
   output logic [32:0] Block_Array,
   output logic [1:0]  lives,
   output logic [15:0] score,
   output logic        bounce_y,
   output logic        start_menu,
   output logic        game_over,
   output logic        game_won
);

   localparam int          IW      = $clog2(NUM_BLOCKS);
   localparam logic [15:0] HIT_BCD = to_bcd(HIT_POINTS);

   game_state_t           game_q;
   scan_state_t           scan_q;
   logic [NUM_BLOCKS-1:0] bricks_q, bricks_clr;
   logic [1:0]            lives_q, lives_d;
   logic [15:0]           score_q, score_sum;
   logic [IW-1:0]         idx_q;
   logic [9:0]            bx_q, by_q, br_q;
   logic                  fs1_q, fs2_q, fs3_q;
   logic                  bounce_q, menu_q, over_q, won_q;
   logic                  frame_edge, lost, in_hit, won, hit;
   logic [10:0]           cx, cy, lim_x, lim_y;

   assign frame_edge = fs2_q & ~fs3_q;
   assign lost       = ball_lost & (game_q == PLAY);
   assign in_hit     = (scan_q == HIT);

   // Brick centre derived from the running scan index.
   assign cx = 11'(idx_q[BRICK_COL_W-1:0]) * 11'(BRICK_PITCH_X)
             + 11'(BRICK_OFFSET_X);
   assign cy = 11'(idx_q[IW-1:BRICK_COL_W]) * 11'(BRICK_PITCH_Y)
             + 11'(BRICK_OFFSET_Y);
   assign lim_x = {1'b0, Block_SizeX} + {1'b0, br_q};
   assign lim_y = {1'b0, Block_SizeY} + {1'b0, br_q};
   assign hit = bricks_q[idx_q]
              & (abs_diff({1'b0, bx_q}, cx) <= lim_x)
              & (abs_diff({1'b0, by_q}, cy) <= lim_y);

   assign bricks_clr = bricks_q & ~(NUM_BLOCKS'(1) << idx_q);
   assign won        = in_hit & (bricks_clr == '0);

   bcd_add4 u_add (
      .a_i   (score_q),
      .b_i   (HIT_BCD),
      .sum_o (score_sum)
   );

`ifdef EXTRA_LIFE_EN
   logic gain;
   // Hundreds digit odd -> even marks a fresh 200-point boundary.
   assign gain = in_hit & score_q[8] & ~score_sum[8] & (score_sum != score_q);

   always_comb begin
      lives_d = lives_q;
      if (gain && !lost) begin
         lives_d = (lives_q == 2'd3) ? lives_q : lives_q + 2'd1;
      end else if (lost && !gain && lives_q != 2'd0) begin
         lives_d = lives_q - 2'd1;
      end
   end
`else
   always_comb begin
      lives_d = lives_q;
      if (lost && lives_q != 2'd0) begin
         lives_d = lives_q - 2'd1;
      end
   end
`endif

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         game_q   <= MENU;
         scan_q   <= IDLE;
         bricks_q <= '1;
         lives_q  <= 2'(START_LIVES);
         score_q  <= '0;
         idx_q    <= '0;
         bx_q     <= '0;
         by_q     <= '0;
         br_q     <= '0;
         fs1_q    <= 1'b0;
         fs2_q    <= 1'b0;
         fs3_q    <= 1'b0;
         bounce_q <= 1'b0;
         menu_q   <= 1'b1;
         over_q   <= 1'b0;
         won_q    <= 1'b0;
      end else begin
         fs1_q    <= frame_clk;
         fs2_q    <= fs1_q;
         fs3_q    <= fs2_q;
         bounce_q <= 1'b0;
         lives_q  <= lives_d;
         unique case (game_q)
            MENU: begin
               if (!(keycode inside {8'h00, 8'h04, 8'h07, 8'h2C})) begin
                  game_q <= PLAY;
                  menu_q <= 1'b0;
               end
            end
            PLAY: begin
               if (won) begin
                  game_q <= WIN;
                  won_q  <= 1'b1;
               end else if (lost && lives_d == 2'd0) begin
                  game_q <= OVER;
                  over_q <= 1'b1;
               end
            end
            OVER, WIN: begin
               if (keycode == KEY_ENTER) begin
                  game_q   <= MENU;
                  bricks_q <= '1;
                  lives_q  <= 2'(START_LIVES);
                  score_q  <= '0;
                  menu_q   <= 1'b1;
                  over_q   <= 1'b0;
                  won_q    <= 1'b0;
               end
            end
            default: game_q <= MENU;
         endcase
         if (game_q != PLAY) begin
            scan_q <= IDLE;
         end else begin
            unique case (scan_q)
               IDLE: begin
                  if (frame_edge) begin
                     bx_q   <= BallX;
                     by_q   <= BallY;
                     br_q   <= Ball_size;
                     idx_q  <= '0;
                     scan_q <= SCAN;
                  end
               end
               SCAN: begin
                  if (hit) begin
                     scan_q   <= HIT;
                     bounce_q <= 1'b1;
                  end else if (idx_q == IW'(NUM_BLOCKS - 1)) begin
                     scan_q <= IDLE;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
               HIT: begin
                  bricks_q <= bricks_clr;
                  score_q  <= score_sum;
                  scan_q   <= IDLE;
               end
               default: scan_q <= IDLE;
            endcase
         end
      end
   end

   assign Block_Array = {1'b0, bricks_q};
   assign lives       = lives_q;
   assign score       = score_q;
   assign bounce_y    = bounce_q;
   assign start_menu  = menu_q;
   assign game_over   = over_q;
   assign game_won    = won_q;

endmodule
